// File: rtl/mp_io_host_if.sv
// Operator-side switch port of the Microprocessor: byte queue write port,
// Input/Enter handshake toward the processor, and Output/Halt result capture.
interface mp_io_host_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       busy;
    logic [7:0] Input;
    logic       Enter;
    logic [7:0] Output;
    logic       Halt;
    logic [7:0] result_data;
    logic       result_valid;

    modport master (
        output wr_en, wr_data, Output, Halt,
        input  full, empty, busy, Input, Enter, result_data, result_valid
    );

    modport slave (
        input  wr_en, wr_data, Output, Halt,
        output full, empty, busy, Input, Enter, result_data, result_valid
    );
endinterface

// File: rtl/mp_io_host.sv
// Host-side operator for the Microprocessor switch port: queues host bytes, strobes
// each onto Input with a timed Enter pulse, and captures Output on the rising edge of Halt.
module mp_io_host #(
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mp_io_host_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 8;

    typedef enum logic [1:0] {IDLE, SETUP, HOLD, GAP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    input_q;
    logic          enter_q;
    logic [7:0]    result_data_q;
    logic          result_valid_q;
    logic          halt_q;

    logic halt_rise;
    logic full;
    logic empty;
    logic pop_go;
    logic push_go;

    always_comb begin
        full      = (count_q == (AW+1)'(DEPTH));
        empty     = (count_q == '0);
        halt_rise = bus.Halt & ~halt_q;
        pop_go    = (state_q == IDLE) & ~empty & ~bus.Halt;
        // A slot freed by a same-cycle pop lets a push into a full queue.
        push_go   = bus.wr_en & (~full | pop_go) & ~halt_rise;
    end

    always_ff @(posedge clk_i) begin
        if (push_go) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            input_q        <= '0;
            enter_q        <= 1'b0;
            result_data_q  <= '0;
            result_valid_q <= 1'b0;
            halt_q         <= 1'b0;
        end else begin
            halt_q         <= bus.Halt;
            result_valid_q <= 1'b0;
            if (halt_rise) begin
                // Program finished: capture its result and abandon everything pending.
                result_data_q  <= bus.Output;
                result_valid_q <= 1'b1;
                enter_q        <= 1'b0;
                state_q        <= IDLE;
                cnt_q          <= '0;
                rd_ptr_q       <= '0;
                wr_ptr_q       <= '0;
                count_q        <= '0;
            end else begin
                if (push_go) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop_go) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                if (push_go && !pop_go) begin
                    count_q <= count_q + 1'b1;
                end else if (pop_go && !push_go) begin
                    count_q <= count_q - 1'b1;
                end

                unique case (state_q)
                    IDLE: begin
                        enter_q <= 1'b0;
                        if (pop_go) begin
                            input_q <= mem_q[rd_ptr_q];
                            cnt_q   <= CW'(SETUP_CYC - 1);
                            state_q <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (cnt_q == '0) begin
                            enter_q <= 1'b1;
                            cnt_q   <= CW'(HOLD_CYC - 1);
                            state_q <= HOLD;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    HOLD: begin
                        if (cnt_q == '0) begin
                            enter_q <= 1'b0;
                            cnt_q   <= CW'(GAP_CYC - 1);
                            state_q <= GAP;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.busy         = (state_q != IDLE);
    assign bus.Input        = input_q;
    assign bus.Enter        = enter_q;
    assign bus.result_data  = result_data_q;
    assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_mp_io_host.sv
// Bench for mp_io_host: a byte-queue/timeline model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_mp_io_host;
    localparam int DEPTH = 4;
    localparam int SETUP = 2;
    localparam int HOLD  = 4;
    localparam int GAP   = 4;
    localparam int TOT   = SETUP + HOLD + GAP;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mp_io_host_if bus ();

    mp_io_host #(
        .DEPTH(DEPTH), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .GAP_CYC(GAP)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Model: queue contents plus cycles elapsed since the current byte was popped.
    logic [7:0] mq[$];
    bit         m_active = 0;
    int         m_t = 0;
    logic [7:0] m_inp = 0;
    logic [7:0] m_res = 0;
    bit         m_rv = 0;
    bit         m_halt_prev = 0;
    bit         m_rise, m_pop, m_push;
    bit         chk_en = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_active = 0; m_t = 0; m_inp = 0; m_res = 0; m_rv = 0; m_halt_prev = 0;
        end else begin
            m_rise = bus.Halt && !m_halt_prev;
            m_rv = 0;
            if (m_rise) begin
                m_res = bus.Output;
                m_rv = 1;
                mq.delete();
                m_active = 0;
            end else begin
                m_pop  = !m_active && mq.size() > 0 && !bus.Halt;
                m_push = bus.wr_en && (mq.size() < DEPTH || m_pop);
                if (m_pop) begin
                    m_inp = mq.pop_front();
                    m_active = 1;
                    m_t = 0;
                end else if (m_active) begin
                    m_t++;
                    if (m_t >= TOT) m_active = 0;
                end
                if (m_push) mq.push_back(bus.wr_data);
            end
            m_halt_prev = bus.Halt;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("m_enter", bus.Enter, m_active && m_t >= SETUP && m_t < SETUP + HOLD);
            chk("m_busy", bus.busy, m_active);
            chk("m_input", bus.Input, m_inp);
            chk("m_empty", bus.empty, mq.size() == 0);
            chk("m_full", bus.full, mq.size() == DEPTH);
            chk("m_rdata", bus.result_data, m_res);
            chk("m_rvalid", bus.result_valid, m_rv);
        end
    end

    // Bytes actually presented: Input at each Enter rising edge.
    logic [7:0] pres[$];
    logic [7:0] exp_q[$];
    logic       prev_enter = 1'b0;
    always @(negedge clk) begin
        if (bus.Enter === 1'b1 && prev_enter !== 1'b1) pres.push_back(bus.Input);
        prev_enter = bus.Enter;
    end

    task automatic check_pres(input string name);
        chk({name, "_count"}, 16'(pres.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < pres.size(); i++)
            chk({name, "_byte"}, pres[i], exp_q[i]);
        pres.delete();
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k = 0;
        while (!(bus.busy === 1'b0 && bus.empty === 1'b1) && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_idle_in_time"}, k < bound, 1);
    endtask

    task automatic push1(input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int first, ones, rv_cnt, k;
        bit found;
        bus.wr_en = 0; bus.wr_data = 0; bus.Halt = 0; bus.Output = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_enter", bus.Enter, 0);
        chk("rst_input", bus.Input, 0);
        chk("rst_rvalid", bus.result_valid, 0);
        chk("rst_rdata", bus.result_data, 0);
        rst = 0;
        chk_en = 1;
        @(negedge clk);

        // Single byte: Enter first seen 4 negedges after the push is driven, high for 4.
        bus.wr_en = 1; bus.wr_data = 8'h5A;
        first = 0; ones = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) bus.wr_en = 0;
            if (i == 2) chk("s1_input", bus.Input, 8'h5A);
            if (bus.Enter === 1'b1) begin
                ones++;
                if (first == 0) first = i;
            end
        end
        chk("s1_enter_rise", 16'(first), 4);
        chk("s1_enter_width", 16'(ones), 4);
        wait_idle("s1", 30);
        exp_q = '{8'h5A};
        check_pres("s1_pres");

        // Fill while busy: 5th byte dropped, then a push lands on the pop of a full queue.
        push1(8'hAA);
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            bus.wr_en = 1; bus.wr_data = 8'(i);
            @(negedge clk);
            if (i == 4) chk("s2_full_after_4th", bus.full, 1);
        end
        bus.wr_en = 0;
        chk("s2_full_after_5th", bus.full, 1);
        found = 0;
        k = 0;
        while (!found && k < 40) begin
            if (bus.busy === 1'b0 && bus.full === 1'b1) begin
                push1(8'h06);
                chk("s2_full_push_pop", bus.full, 1);
                chk("s2_busy_after_pop", bus.busy, 1);
                found = 1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk("s2_pop_seen", found, 1);
        wait_idle("s2", 200);
        exp_q = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        check_pres("s2_pres");

        // Halt rises mid-HOLD with bytes queued and a simultaneous push.
        bus.Output = 8'hC3;
        push1(8'h77); push1(8'h78); push1(8'h79);
        k = 0;
        while (bus.Enter !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("s3_enter_seen", k < 20, 1);
        @(negedge clk);
        bus.Halt = 1; bus.wr_en = 1; bus.wr_data = 8'h99;
        @(negedge clk);
        bus.wr_en = 0;
        chk("s3_enter_abort", bus.Enter, 0);
        chk("s3_rvalid", bus.result_valid, 1);
        chk("s3_rdata", bus.result_data, 8'hC3);
        chk("s3_empty", bus.empty, 1);
        chk("s3_busy", bus.busy, 0);
        @(negedge clk);
        chk("s3_rvalid_once", bus.result_valid, 0);
        exp_q = '{8'h77};
        check_pres("s3_pres");

        // Halt held: push is kept but not presented until Halt falls.
        bus.Output = 8'h3C;
        push1(8'h11);
        ones = 0; rv_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.Enter === 1'b1) ones++;
            if (bus.result_valid === 1'b1) rv_cnt++;
        end
        chk("s4_no_enter_halted", 16'(ones), 0);
        chk("s4_held_not_empty", bus.empty, 0);
        chk("s4_idle_halted", bus.busy, 0);
        bus.Halt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.Enter === 1'b1) ones++;
            if (bus.result_valid === 1'b1) rv_cnt++;
        end
        chk("s4_enter_width", 16'(ones), 4);
        chk("s4_no_second_rvalid", 16'(rv_cnt), 0);
        chk("s4_input", bus.Input, 8'h11);
        wait_idle("s4", 30);
        exp_q = '{8'h11};
        check_pres("s4_pres");

        // Reset during SETUP with 3 bytes still queued.
        bus.Halt = 1;
        @(negedge clk);
        push1(8'hA1); push1(8'hA2); push1(8'hA3); push1(8'hA4);
        chk("s5_full_halted", bus.full, 1);
        bus.Halt = 0;
        k = 0;
        while (bus.busy !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("s5_busy_seen", k < 10, 1);
        chk("s5_input_a1", bus.Input, 8'hA1);
        chk("s5_three_left", bus.full, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("s5_rst_enter", bus.Enter, 0);
        chk("s5_rst_input", bus.Input, 0);
        chk("s5_rst_busy", bus.busy, 0);
        chk("s5_rst_empty", bus.empty, 1);
        chk("s5_rst_full", bus.full, 0);
        chk("s5_rst_rvalid", bus.result_valid, 0);
        chk("s5_rst_rdata", bus.result_data, 0);
        repeat (12) @(negedge clk);
        chk("s5_stays_idle", bus.busy, 0);
        exp_q = '{};
        check_pres("s5_pres");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
